pipeline_skid_n: RTL and testbench

PIPELINE_SKID_N -- requirements
Module: pipeline_skid_N

---
 rtl/haze_pkg.sv | 23 ++
 rtl/pipeline_skid_n_register.sv | 21 ++
 rtl/pipeline_skid_n.sv | 102 ++++++++++
 tb/tb_pipeline_skid_n.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/haze_pkg.sv
// Shared types for the pipeline skid stage: state encoding and occupancy decode.
package haze_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned OCC_W   = 2;

  // Encoding equals the number of held entries.
  typedef enum logic [STATE_W-1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Entries held for a given state; unreachable encodings report zero.
  function automatic logic [OCC_W-1:0] occupancy_of(input skid_state_t s);
    case (s)
      BUSY:    occupancy_of = OCC_W'(1);
      FULL:    occupancy_of = OCC_W'(2);
      default: occupancy_of = OCC_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/pipeline_skid_n_register.sv
// N-bit storage register with write enable and async active-high clear.
module register_N #(
  parameter int unsigned N = 32
) (
  input  logic         i_Clock,
  input  logic         i_Reset,
  input  logic         i_Enable,
  input  logic [N-1:0] i_Data,
  output logic [N-1:0] o_Data
);

  // Load on enable, clear immediately on reset.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_Data <= '0;
    end else if (i_Enable) begin
      o_Data <= i_Data;
    end
  end

endmodule

// File: rtl/pipeline_skid_n.sv
// Two-entry skid buffer: main register drives the output, skid register absorbs
// the one extra beat accepted while downstream stalls. Ready depends on state only.
module pipeline_skid_n
  import haze_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Flush,
  input  logic             i_InValid,
  input  logic [N-1:0]     i_InData,
  output logic             o_InReady,
  output logic             o_OutValid,
  output logic [N-1:0]     o_OutData,
  input  logic             i_OutReady,
  output logic [OCC_W-1:0] o_Occupancy
);

  skid_state_t r_State;
  skid_state_t w_NextState;
  logic         w_MainEn;
  logic         w_SkidEn;
  logic [N-1:0] w_MainD;
  logic [N-1:0] w_Main;
  logic [N-1:0] w_Skid;
  logic         w_InXfer;
  logic         w_OutXfer;

  // Status outputs are pure decodes of the state flops.
  assign o_InReady   = (r_State != FULL);
  assign o_OutValid  = (r_State != EMPTY);
  assign o_OutData   = w_Main;
  assign o_Occupancy = occupancy_of(r_State);

  assign w_InXfer  = i_InValid & o_InReady;
  assign w_OutXfer = o_OutValid & i_OutReady;

  // Next-state and register-enable decode; flush overrides all transfers.
  always_comb begin
    w_NextState = r_State;
    w_MainEn    = 1'b0;
    w_SkidEn    = 1'b0;
    w_MainD     = i_InData;
    if (i_Flush) begin
      w_NextState = EMPTY;
    end else begin
      case (r_State)
        EMPTY: begin
          if (w_InXfer) begin
            w_NextState = BUSY;
            w_MainEn    = 1'b1;
          end
        end
        BUSY: begin
          if (w_InXfer && w_OutXfer) begin
            w_MainEn = 1'b1;
          end else if (w_InXfer) begin
            w_NextState = FULL;
            w_SkidEn    = 1'b1;
          end else if (w_OutXfer) begin
            w_NextState = EMPTY;
          end
        end
        FULL: begin
          if (w_OutXfer) begin
            w_NextState = BUSY;
            w_MainEn    = 1'b1;
            w_MainD     = w_Skid;
          end
        end
        default: w_NextState = EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State <= EMPTY;
    end else begin
      r_State <= w_NextState;
    end
  end

  register_N #(.N(N)) u_main (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Enable (w_MainEn),
    .i_Data   (w_MainD),
    .o_Data   (w_Main)
  );

  register_N #(.N(N)) u_skid (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Enable (w_SkidEn),
    .i_Data   (i_InData),
    .o_Data   (w_Skid)
  );

endmodule

// File: tb/tb_pipeline_skid_n.sv
// Bench for pipeline_skid_n: queue model checked every negedge plus directed literals.
module tb_pipeline_skid_n;

  localparam int unsigned N = 32;

  logic          i_Clock = 1'b0;
  logic          i_Reset = 1'b0;
  logic          i_Flush = 1'b0;
  logic          i_InValid = 1'b0;
  logic [N-1:0]  i_InData = '0;
  logic          i_OutReady = 1'b0;
  logic          o_InReady;
  logic          o_OutValid;
  logic [N-1:0]  o_OutData;
  logic [1:0]    o_Occupancy;

  int n_cmp = 0;
  int n_err = 0;

  logic [N-1:0] q[$];
  logic [N-1:0] out_log[$];
  bit           watch55 = 1'b0;
  bit           seen55 = 1'b0;

  pipeline_skid_n #(.N(N)) dut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Flush     (i_Flush),
    .i_InValid   (i_InValid),
    .i_InData    (i_InData),
    .o_InReady   (o_InReady),
    .o_OutValid  (o_OutValid),
    .o_OutData   (o_OutData),
    .i_OutReady  (i_OutReady),
    .o_Occupancy (o_Occupancy)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of depth two; reset/flush empty it, pop then push per edge.
  always @(posedge i_Reset) q.delete();

  always @(posedge i_Clock) begin
    if (i_Reset || i_Flush) begin
      q.delete();
    end else begin
      bit do_in;
      bit do_out;
      do_in  = i_InValid && (q.size() < 2);
      do_out = i_OutReady && (q.size() > 0);
      if (do_out) begin
        out_log.push_back(q[0]);
        void'(q.pop_front());
      end
      if (do_in) q.push_back(i_InData);
    end
  end

  // Per-cycle comparison of DUT status and head-of-queue data against the model.
  always @(negedge i_Clock) begin
    check("m_occ", 64'(o_Occupancy), 64'(q.size()));
    check("m_valid", 64'(o_OutValid), 64'(q.size() != 0));
    check("m_ready", 64'(o_InReady), 64'(q.size() < 2));
    if (q.size() != 0) check("m_data", 64'(o_OutData), 64'(q[0]));
    if (watch55 && o_OutValid && o_OutData == 32'h55) seen55 = 1'b1;
  end

  // Drive one cycle of inputs starting at a negedge, return at the next negedge.
  task automatic step(input logic iv, input logic [N-1:0] d, input logic ordy, input logic fl);
    i_InValid  = iv;
    i_InData   = d;
    i_OutReady = ordy;
    i_Flush    = fl;
    @(negedge i_Clock);
  endtask

  initial begin
    #1 i_Reset = 1'b1;
    #1;
    check("rst_valid", 64'(o_OutValid), 64'd0);
    check("rst_occ", 64'(o_Occupancy), 64'd0);
    check("rst_ready", 64'(o_InReady), 64'd1);
    check("rst_data", 64'(o_OutData), 64'd0);
    @(negedge i_Clock);
    @(negedge i_Clock);
    i_Reset = 1'b0;

    // Single entry, one-cycle latency.
    step(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
    check("single_valid", 64'(o_OutValid), 64'd1);
    check("single_data", 64'(o_OutData), 64'hA5A5A5A5);
    check("single_occ", 64'(o_Occupancy), 64'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("single_drain_occ", 64'(o_Occupancy), 64'd0);

    // Backpressure fill; third offer refused.
    out_log.delete();
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    check("fill_occ", 64'(o_Occupancy), 64'd2);
    check("fill_ready", 64'(o_InReady), 64'd0);
    check("fill_data", 64'(o_OutData), 64'h11);
    step(1'b1, 32'h33, 1'b0, 1'b0);
    check("fill_hold_occ", 64'(o_Occupancy), 64'd2);
    check("fill_hold_data", 64'(o_OutData), 64'h11);

    // Drain.
    step(1'b0, '0, 1'b1, 1'b0);
    check("drain1_data", 64'(o_OutData), 64'h22);
    step(1'b0, '0, 1'b1, 1'b0);
    check("drain_valid", 64'(o_OutValid), 64'd0);
    check("drain_ready", 64'(o_InReady), 64'd1);
    check("drain_log_n", 64'(out_log.size()), 64'd2);
    if (out_log.size() == 2) begin
      check("drain_log0", 64'(out_log[0]), 64'h11);
      check("drain_log1", 64'(out_log[1]), 64'h22);
    end

    // Flush with a same-cycle offer and pop: all discarded, registers untouched.
    step(1'b1, 32'h44, 1'b0, 1'b0);
    step(1'b1, 32'h66, 1'b0, 1'b0);
    check("pre_flush_occ", 64'(o_Occupancy), 64'd2);
    watch55 = 1'b1;
    step(1'b1, 32'h55, 1'b1, 1'b1);
    check("flush_occ", 64'(o_Occupancy), 64'd0);
    check("flush_valid", 64'(o_OutValid), 64'd0);
    check("flush_main_kept", 64'(o_OutData), 64'h44);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("flush_no55", 64'(seen55), 64'd0);
    watch55 = 1'b0;

    // Async reset between edges while FULL.
    step(1'b1, 32'h77, 1'b0, 1'b0);
    step(1'b1, 32'h88, 1'b0, 1'b0);
    check("pre_rst_occ", 64'(o_Occupancy), 64'd2);
    i_InValid = 1'b0;
    #2 i_Reset = 1'b1;
    #1;
    check("arst_valid", 64'(o_OutValid), 64'd0);
    check("arst_occ", 64'(o_Occupancy), 64'd0);
    check("arst_data", 64'(o_OutData), 64'd0);
    check("arst_ready", 64'(o_InReady), 64'd1);
    // Offer during reset edge must be ignored.
    i_InValid = 1'b1;
    i_InData  = 32'h99;
    @(negedge i_Clock);
    check("rst_edge_occ", 64'(o_Occupancy), 64'd0);
    i_Reset = 1'b0;
    step(1'b1, 32'h99, 1'b0, 1'b0);
    check("post_rst_occ", 64'(o_Occupancy), 64'd1);
    check("post_rst_data", 64'(o_OutData), 64'h99);
    step(1'b0, '0, 1'b1, 1'b0);

    // Streaming 0..99 at full rate.
    out_log.delete();
    for (int i = 0; i < 100; i++) begin
      step(1'b1, N'(i), 1'b1, 1'b0);
      check("stream_occ", 64'(o_Occupancy), 64'd1);
      check("stream_data", 64'(o_OutData), 64'(i));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    check("stream_n", 64'(out_log.size()), 64'd100);
    for (int i = 0; i < out_log.size() && i < 100; i++) begin
      check("stream_order", 64'(out_log[i]), 64'(i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
